// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Iterative radix-2 restoring divider for the execute stage.
//                DIV/DIVU with HI/LO result, pipeline stall request and
//                synchronous cancel.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               stall_req,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q;      // |divisor|
    logic             sdiv_q;
    logic             sgnq_q;
    logic             sgnr_q;
    logic             dz_q;
    logic [2*WIDTH-1:0] result_q;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    assign w_accept = (state_q == S_IDLE) && start && !cancel;
    assign w_last   = (state_q == S_RUN) && (cnt_q == LAST) && !cancel;

    // Magnitudes are taken only for signed divides
    assign w_a_abs  = (signed_div && a[WIDTH-1]) ? -a : a;
    assign w_b_abs  = (signed_div && b[WIDTH-1]) ? -b : b;

    // One restoring step; the borrow of the 33-bit subtraction decides the bit
    assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, dvs_q};
    assign w_ge     = !w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {quo_q[WIDTH-2:0], w_ge};

    // Sign correction; with a zero divisor the remainder ends as |a|, so
    // re-applying the dividend sign restores the original a
    assign w_hi = (sdiv_q && sgnr_q) ? -w_rem_nx : w_rem_nx;
    assign w_lo = dz_q ? {WIDTH{1'b1}} : ((sdiv_q && sgnq_q) ? -w_quo_nx : w_quo_nx);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; cancel overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)          state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST)  state_d = S_DONE;
            S_DONE:                      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
        if (cancel) state_d = S_IDLE;
    end

    // Outputs: stall while accepting or iterating, ready only in an uncancelled DONE
    always_comb begin
        stall_req = !rst && (w_accept || (state_q == S_RUN));
        ready     = !rst && !cancel && (state_q == S_DONE);
    end

    // Operand latch, iteration datapath and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            sdiv_q <= 1'b0;
            sgnq_q <= 1'b0;
            sgnr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (cancel) begin
            cnt_q  <= '0;
        end else if (w_accept) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= w_a_abs;
            dvs_q  <= w_b_abs;
            sdiv_q <= signed_div;
            sgnq_q <= a[WIDTH-1] ^ b[WIDTH-1];
            sgnr_q <= a[WIDTH-1];
            dz_q   <= (b == '0);
        end else if (state_q == S_RUN) begin
            cnt_q  <= cnt_q + CW'(1);
            rem_q  <= w_rem_nx;
            quo_q  <= w_quo_nx;
        end
    end

    // Result loads on the final step so it is visible during DONE
    always_ff @(posedge clk) begin
        if (rst)         result_q <= '0;
        else if (w_last) result_q <= {w_hi, w_lo};
    end

    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter
//  Description : Self-checking bench for div_iter against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        stall_req;
    logic        ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res;

    div_iter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .stall_req  (stall_req),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // HI/LO reference from plain integer arithmetic
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy, q, r;
        logic [31:0] q32, r32;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        q32 = q[31:0];
        r32 = r[31:0];
        return {r32, q32};
    endfunction

    // Issue one divide at a negedge and follow it cycle by cycle to DONE
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] exp;
        exp = ref_div(x, y, s);
        @(negedge clk);
        start = 1'b1; a = x; b = y; signed_div = s;
        #1;
        check("stall_at_t", {63'd0, stall_req}, 64'd1);
        check("ready_at_t", {63'd0, ready}, 64'd0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start = 1'b0; a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
            #1;
            if (k < 33) begin
                check("stall_run", {63'd0, stall_req}, 64'd1);
                check("ready_run", {63'd0, ready}, 64'd0);
            end else begin
                check("ready_done", {63'd0, ready}, 64'd1);
                check("stall_done", {63'd0, stall_req}, 64'd0);
                check("result", result, exp);
            end
        end
        last_res = exp;
        @(negedge clk);
        #1;
        check("ready_after", {63'd0, ready}, 64'd0);
        check("result_hold", result, exp);
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic        rs;
        int          nready;

        rst = 1'b1; start = 1'b1; signed_div = 1'b0; a = 32'd5; b = 32'd1; cancel = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {63'd0, stall_req}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_res = 64'd0;

        // Directed cases
        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(32'h1234_5678, 32'd0, 1'b0);
        do_op(32'hF000_0001, 32'd0, 1'b1);

        // Cancel at RUN iteration 10
        @(negedge clk);
        start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        cancel = 1'b1;
        #1;
        check("cancel_stall_run", {63'd0, stall_req}, 64'd1);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_idle_stall", {63'd0, stall_req}, 64'd0);
        nready = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (ready) nready++;
        end
        check("cancel_no_ready", 64'(nready), 64'd0);
        check("cancel_keep_result", result, last_res);
        do_op(32'd9, 32'd3, 1'b0);

        // Start held high across DONE: two operations, ready at t+33 and t+67
        @(negedge clk);
        start = 1'b1; a = 32'd9; b = 32'd3; signed_div = 1'b0;
        nready = 0;
        for (int k = 1; k <= 67; k++) begin
            @(negedge clk);
            #1;
            if (ready) nready++;
            if (k == 33 || k == 67) begin
                check("hold_ready", {63'd0, ready}, 64'd1);
                check("hold_result", result, 64'h0000_0000_0000_0003);
            end
            if (k == 34) check("hold_restart_stall", {63'd0, stall_req}, 64'd1);
        end
        start = 1'b0;
        check("hold_ready_count", 64'(nready), 64'd2);

        // Reset mid-RUN with start asserted
        @(negedge clk);
        #1;
        start = 1'b1; a = 32'd77; b = 32'd5;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_ready", {63'd0, ready}, 64'd0);
        check("rst_mid_stall", {63'd0, stall_req}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Same-cycle start + cancel in IDLE
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; a = 32'd50; b = 32'd5;
        #1;
        check("sc_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        check("sc_idle_stall", {63'd0, stall_req}, 64'd0);
        nready = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (ready) nready++;
        end
        check("sc_no_ready", 64'(nready), 64'd0);

        // Randomized operations
        for (int n = 0; n < 16; n++) begin
            rx = $urandom;
            ry = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ry = 32'($urandom_range(0, 15));
                1: ry = rs ? -32'($urandom_range(1, 15)) : ry;
                2: rx = 32'($urandom_range(0, 255));
                default: ;
            endcase
            do_op(rx, ry, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
